// File: rtl/aes_pkg.sv
// Shared types for the AES-128 request controller: block width, command
// opcodes and the controller FSM states.
package aes_pkg;

   localparam int AES_BLOCK_W = 128;

   typedef enum logic [1:0] {
      AES_OP_LOAD_KEY = 2'd0,
      AES_OP_ENC      = 2'd1,
      AES_OP_DEC      = 2'd2,
      AES_OP_RSVD     = 2'd3
   } aes_op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_BUSY   = 3'd3,
      ST_RESP   = 3'd4
   } aes_ctrl_state_e;

endpackage

// File: rtl/aes_wdt_counter.sv
// Up-counter with synchronous clear and enable; expired is high while the
// count sits on its last value (LIMIT-1), or permanently when LIMIT is 0.
module aes_wdt_counter #(
   parameter int LIMIT = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = ($clog2(LIMIT + 1) < 1) ? 1 : $clog2(LIMIT + 1);
   localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (LIMIT == 0) || (cnt == LAST);

endmodule

// File: rtl/aes128_req_ctrl.sv
// Initiator-side controller for aes128_core: accepts LOAD_KEY/ENC/DEC requests,
// strobes the core, waits for done (with a watchdog) and returns a response.
// Both streams transfer a beat in any cycle where valid && ready are high;
// valid never depends on ready, and a response is held stable until taken.
module aes128_req_ctrl
   import aes_pkg::*;
#(
   parameter int KEY_SETTLE_CYCLES = 2,
   parameter int TIMEOUT_CYCLES    = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [1:0]             req_op_i,
   input  logic [AES_BLOCK_W-1:0] req_data_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [AES_BLOCK_W-1:0] rsp_data_o,
   output logic                   rsp_err_o,
   output logic                   key_loaded_o,
   output logic                   core_load_key_o,
   output logic                   core_start_enc_o,
   output logic                   core_start_dec_o,
   output logic [AES_BLOCK_W-1:0] core_data_o,
   input  logic [AES_BLOCK_W-1:0] core_data_i,
   input  logic                   core_ready_i,
   input  logic                   core_done_i
);

   aes_ctrl_state_e        state, state_d;
   aes_op_e                op_q, req_op;
   logic [AES_BLOCK_W-1:0] core_data_q, rsp_data_q, rsp_data_d;
   logic                   rsp_err_q, rsp_err_d, rsp_load;
   logic                   key_loaded_q, key_set, accept;
   logic                   req_ready, rsp_valid, load_stb, enc_stb, dec_stb;
   logic                   settle_en, settle_exp, busy_en, busy_exp;

   assign req_op = aes_op_e'(req_op_i);

   aes_wdt_counter #(.LIMIT(KEY_SETTLE_CYCLES)) u_settle_cnt (
      .clk     (clk),
      .clr     (rst || (state != ST_SETTLE)),
      .en      (settle_en),
      .expired (settle_exp)
   );

   aes_wdt_counter #(.LIMIT(TIMEOUT_CYCLES)) u_busy_cnt (
      .clk     (clk),
      .clr     (rst || (state != ST_BUSY)),
      .en      (busy_en),
      .expired (busy_exp)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         op_q         <= AES_OP_LOAD_KEY;
         core_data_q  <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
         key_loaded_q <= 1'b0;
      end else begin
         state <= state_d;
         if (accept) begin
            op_q        <= req_op;
            core_data_q <= req_data_i;
         end
         if (rsp_load) begin
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
         end
         if (key_set) begin
            key_loaded_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state;
      accept     = 1'b0;
      rsp_load   = 1'b0;
      rsp_err_d  = 1'b0;
      rsp_data_d = '0;
      key_set    = 1'b0;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      load_stb   = 1'b0;
      enc_stb    = 1'b0;
      dec_stb    = 1'b0;
      settle_en  = 1'b0;
      busy_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid_i) begin
               accept = 1'b1;
               // Illegal requests are answered locally and never reach the core
               if ((req_op == AES_OP_RSVD) ||
                   ((req_op != AES_OP_LOAD_KEY) && !key_loaded_q)) begin
                  state_d   = ST_RESP;
                  rsp_load  = 1'b1;
                  rsp_err_d = 1'b1;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (core_ready_i) begin
               case (op_q)
                  AES_OP_LOAD_KEY: begin
                     load_stb = 1'b1;
                     if (KEY_SETTLE_CYCLES == 0) begin
                        state_d  = ST_RESP;
                        rsp_load = 1'b1;
                        key_set  = 1'b1;
                     end else begin
                        state_d = ST_SETTLE;
                     end
                  end
                  AES_OP_ENC: begin
                     enc_stb = 1'b1;
                     state_d = ST_BUSY;
                  end
                  AES_OP_DEC: begin
                     dec_stb = 1'b1;
                     state_d = ST_BUSY;
                  end
                  default: begin
                     state_d   = ST_RESP;
                     rsp_load  = 1'b1;
                     rsp_err_d = 1'b1;
                  end
               endcase
            end
         end
         ST_SETTLE: begin
            settle_en = 1'b1;
            if (settle_exp) begin
               state_d  = ST_RESP;
               rsp_load = 1'b1;
               key_set  = 1'b1;
            end
         end
         ST_BUSY: begin
            busy_en = 1'b1;
            // Done takes priority over a watchdog expiry in the same cycle
            if (core_done_i) begin
               state_d    = ST_RESP;
               rsp_load   = 1'b1;
               rsp_data_d = core_data_i;
            end else if (busy_exp) begin
               state_d   = ST_RESP;
               rsp_load  = 1'b1;
               rsp_err_d = 1'b1;
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Every output reads as zero while reset is held, not just after the edge
   assign req_ready_o      = !rst && req_ready;
   assign rsp_valid_o      = !rst && rsp_valid;
   assign rsp_data_o       = rst ? '0 : rsp_data_q;
   assign rsp_err_o        = !rst && rsp_err_q;
   assign key_loaded_o     = !rst && key_loaded_q;
   assign core_load_key_o  = !rst && load_stb;
   assign core_start_enc_o = !rst && enc_stb;
   assign core_start_dec_o = !rst && dec_stb;
   assign core_data_o      = rst ? '0 : core_data_q;

endmodule

// File: tb/tb_aes128_req_ctrl.sv
// Directed bench for aes128_req_ctrl; the core is modelled inline, replaying
// the FIPS-197 example ciphertext/plaintext on done.
module tb_aes128_req_ctrl;

   localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] JUNK = 128'hdeadbeefcafef00d0123456789abcdef;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid_i, req_ready_o;
   logic [1:0]   req_op_i;
   logic [127:0] req_data_i;
   logic         rsp_valid_o, rsp_ready_i;
   logic [127:0] rsp_data_o;
   logic         rsp_err_o, key_loaded_o;
   logic         core_load_key_o, core_start_enc_o, core_start_dec_o;
   logic [127:0] core_data_o, core_data_i;
   logic         core_ready_i, core_done_i;

   int errors = 0;
   int checks = 0;
   int n_load = 0, n_enc = 0, n_dec = 0;
   int n_enc_saved;

   always #5 clk = ~clk;

   aes128_req_ctrl #(.KEY_SETTLE_CYCLES(2), .TIMEOUT_CYCLES(64)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid_i      (req_valid_i),
      .req_ready_o      (req_ready_o),
      .req_op_i         (req_op_i),
      .req_data_i       (req_data_i),
      .rsp_valid_o      (rsp_valid_o),
      .rsp_ready_i      (rsp_ready_i),
      .rsp_data_o       (rsp_data_o),
      .rsp_err_o        (rsp_err_o),
      .key_loaded_o     (key_loaded_o),
      .core_load_key_o  (core_load_key_o),
      .core_start_enc_o (core_start_enc_o),
      .core_start_dec_o (core_start_dec_o),
      .core_data_o      (core_data_o),
      .core_data_i      (core_data_i),
      .core_ready_i     (core_ready_i),
      .core_done_i      (core_done_i)
   );

   // Strobes seen by the core at each active edge
   always @(posedge clk) begin
      if (core_load_key_o)  n_load <= n_load + 1;
      if (core_start_enc_o) n_enc  <= n_enc + 1;
      if (core_start_dec_o) n_dec  <= n_dec + 1;
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [1:0] op, input logic [127:0] d);
      req_valid_i = 1'b1;
      req_op_i    = op;
      req_data_i  = d;
      #1;
      chk("req_ready_at_accept", req_ready_o, 1'b1);
      cyc();
      req_valid_i = 1'b0;
      req_data_i  = '0;
      #1;
   endtask

   task automatic handshake();
      rsp_ready_i = 1'b1;
      #1;
      cyc();
      rsp_ready_i = 1'b0;
      #1;
      chk("rsp_valid_after_hs", rsp_valid_o, 1'b0);
   endtask

   initial begin
      rst = 1'b1; req_valid_i = 1'b1; req_op_i = 2'd1; req_data_i = PT;
      rsp_ready_i = 1'b0; core_data_i = JUNK; core_ready_i = 1'b1; core_done_i = 1'b0;
      cyc();
      cyc();
      chk("rst_req_ready", req_ready_o, 1'b0);
      chk("rst_rsp_valid", rsp_valid_o, 1'b0);
      chk("rst_key_loaded", key_loaded_o, 1'b0);
      chk("rst_core_data", core_data_o, '0);
      chk("rst_strobes", {core_load_key_o, core_start_enc_o, core_start_dec_o}, 3'b000);
      req_valid_i = 1'b0;
      rst = 1'b0;
      #1;
      chk("idle_req_ready", req_ready_o, 1'b1);

      // ENC before any key is rejected locally
      send(2'd1, PT);
      chk("nokey_rsp_valid", rsp_valid_o, 1'b1);
      chk("nokey_rsp_err", rsp_err_o, 1'b1);
      chk("nokey_rsp_data", rsp_data_o, '0);
      chk("nokey_key_loaded", key_loaded_o, 1'b0);
      chk("nokey_req_ready", req_ready_o, 1'b0);
      handshake();
      chk("nokey_strobes", n_load + n_enc + n_dec, 0);

      // LOAD_KEY: strobe in ISSUE, response 4 cycles after accept
      send(2'd0, KEY);
      chk("lk_strobe", core_load_key_o, 1'b1);
      chk("lk_enc_strobe", core_start_enc_o, 1'b0);
      chk("lk_core_data", core_data_o, KEY);
      chk("lk_valid_c1", rsp_valid_o, 1'b0);
      cyc();
      chk("lk_valid_c2", rsp_valid_o, 1'b0);
      cyc();
      chk("lk_valid_c3", rsp_valid_o, 1'b0);
      chk("lk_key_loaded_early", key_loaded_o, 1'b0);
      cyc();
      chk("lk_valid_c4", rsp_valid_o, 1'b1);
      chk("lk_err", rsp_err_o, 1'b0);
      chk("lk_data", rsp_data_o, '0);
      chk("lk_key_loaded", key_loaded_o, 1'b1);
      handshake();
      chk("lk_load_count", n_load, 1);

      // ENC with done after a few busy cycles
      send(2'd1, PT);
      chk("enc_strobe", core_start_enc_o, 1'b1);
      chk("enc_core_data", core_data_o, PT);
      cyc();
      core_ready_i = 1'b0;
      cyc();
      cyc();
      core_done_i = 1'b1; core_data_i = CT;
      #1;
      chk("enc_valid_in_done", rsp_valid_o, 1'b0);
      cyc();
      core_done_i = 1'b0; core_data_i = JUNK; core_ready_i = 1'b1;
      #1;
      chk("enc_rsp_valid", rsp_valid_o, 1'b1);
      chk("enc_rsp_data", rsp_data_o, CT);
      chk("enc_rsp_err", rsp_err_o, 1'b0);
      handshake();

      // DEC, then a stalled response with a pending request
      send(2'd2, CT);
      chk("dec_strobe", core_start_dec_o, 1'b1);
      cyc();
      core_done_i = 1'b1; core_data_i = PT;
      cyc();
      core_done_i = 1'b0; core_data_i = JUNK;
      req_valid_i = 1'b1; req_op_i = 2'd1; req_data_i = JUNK;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("dec_stall_valid", rsp_valid_o, 1'b1);
         chk("dec_stall_data", rsp_data_o, PT);
         chk("dec_stall_req_ready", req_ready_o, 1'b0);
         cyc();
      end
      req_valid_i = 1'b0;
      handshake();
      chk("dec_core_data_held", core_data_o, CT);

      // Core not ready for 10 cycles, never completes: watchdog fires
      core_ready_i = 1'b0;
      n_enc_saved = n_enc;
      send(2'd1, PT);
      for (int i = 0; i < 10; i++) begin
         chk("to_no_strobe", core_start_enc_o, 1'b0);
         cyc();
      end
      core_ready_i = 1'b1;
      #1;
      chk("to_strobe", core_start_enc_o, 1'b1);
      cyc();
      core_ready_i = 1'b0;
      for (int i = 0; i < 64; i++) begin
         chk("to_busy_no_rsp", rsp_valid_o, 1'b0);
         cyc();
      end
      chk("to_rsp_valid", rsp_valid_o, 1'b1);
      chk("to_rsp_err", rsp_err_o, 1'b1);
      chk("to_rsp_data", rsp_data_o, '0);
      chk("to_single_strobe", n_enc, n_enc_saved + 1);
      core_done_i = 1'b1; core_data_i = CT;
      cyc();
      core_done_i = 1'b0;
      #1;
      chk("to_late_done_err", rsp_err_o, 1'b1);
      chk("to_late_done_data", rsp_data_o, '0);
      handshake();
      core_done_i = 1'b1;
      cyc();
      cyc();
      core_done_i = 1'b0; core_ready_i = 1'b1;
      #1;
      chk("idle_done_ignored", rsp_valid_o, 1'b0);

      // Reserved op, then LOAD_KEY with a stray done during SETTLE
      send(2'd3, JUNK);
      chk("rsvd_rsp_valid", rsp_valid_o, 1'b1);
      chk("rsvd_rsp_err", rsp_err_o, 1'b1);
      chk("rsvd_strobes", {core_load_key_o, core_start_enc_o, core_start_dec_o}, 3'b000);
      handshake();
      chk("rsvd_load_count", n_load, 1);
      send(2'd0, KEY);
      cyc();
      core_done_i = 1'b1; core_data_i = CT;
      cyc();
      core_done_i = 1'b0;
      #1;
      chk("settle_no_rsp", rsp_valid_o, 1'b0);
      cyc();
      chk("reload_rsp_valid", rsp_valid_o, 1'b1);
      chk("reload_rsp_err", rsp_err_o, 1'b0);
      chk("reload_rsp_data", rsp_data_o, '0);
      handshake();
      cyc();
      chk("no_extra_rsp", rsp_valid_o, 1'b0);
      chk("reload_load_count", n_load, 2);

      // Reset while BUSY drops the request and clears key_loaded
      send(2'd1, PT);
      cyc();
      cyc();
      rst = 1'b1;
      #1;
      chk("rstbusy_req_ready", req_ready_o, 1'b0);
      cyc();
      chk("rstbusy_rsp_valid", rsp_valid_o, 1'b0);
      chk("rstbusy_rsp_err", rsp_err_o, 1'b0);
      chk("rstbusy_rsp_data", rsp_data_o, '0);
      chk("rstbusy_key_loaded", key_loaded_o, 1'b0);
      chk("rstbusy_core_data", core_data_o, '0);
      rst = 1'b0;
      cyc();
      chk("rstbusy_no_rsp", rsp_valid_o, 1'b0);
      n_enc_saved = n_enc;
      send(2'd1, PT);
      chk("postrst_rsp_valid", rsp_valid_o, 1'b1);
      chk("postrst_rsp_err", rsp_err_o, 1'b1);
      chk("postrst_rsp_data", rsp_data_o, '0);
      handshake();
      chk("postrst_no_strobe", n_enc, n_enc_saved);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
